// File: rtl/serial_shifter.sv
// serial_shifter: SLL/SRL/SRA/pass unit, one bit per clock (two per clock with SERIAL_SHIFTER_FAST2_EN).
// Latency: done N+1 edges after start (ceil(N/2)+1 with FAST2), 1 edge for N=0 or op 11.
// Backpressure: start is only accepted in IDLE; requests arriving while busy are dropped, not queued.
module serial_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] shift_dat;
  logic [WIDTH-1:0] result_nxt;
  logic [1:0]       opr, opr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [CW-1:0]    count_dec;
  logic             two_step;

  // Only the low log2(WIDTH) bits of Y carry the shift amount.
  logic unused_y_hi;
  assign unused_y_hi = ^Y[WIDTH-1:CW];

`ifdef SERIAL_SHIFTER_FAST2_EN
  assign two_step = (count[CW-1:1] != '0);
`else
  assign two_step = 1'b0;
`endif

  assign count_dec = two_step ? (count - CW'(2)) : (count - CW'(1));

  always_comb begin
    shift_dat = acc;
    case (opr)
      2'b00:   shift_dat = two_step ? {acc[WIDTH-3:0], 2'b00}
                                    : {acc[WIDTH-2:0], 1'b0};
      2'b01:   shift_dat = two_step ? {2'b00, acc[WIDTH-1:2]}
                                    : {1'b0, acc[WIDTH-1:1]};
      2'b10:   shift_dat = two_step ? {{2{acc[WIDTH-1]}}, acc[WIDTH-1:2]}
                                    : {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: shift_dat = acc;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    opr_nxt    = opr;
    count_nxt  = count;
    result_nxt = result;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = X;
          opr_nxt   = op;
          count_nxt = Y[CW-1:0];
          // Zero shift and pass-through complete without touching acc.
          if ((Y[CW-1:0] == '0) || (op == 2'b11)) begin
            state_nxt  = DONE;
            result_nxt = X;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_nxt   = shift_dat;
        count_nxt = count_dec;
        if (count_dec == '0) begin
          state_nxt  = DONE;
          result_nxt = shift_dat;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      opr    <= 2'b00;
      count  <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      opr    <= opr_nxt;
      count  <= count_nxt;
      result <= result_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_shifter.sv
// Testbench for serial_shifter: directed corner cases plus randomized ops against an arithmetic reference model.
module tb_serial_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] X, Y;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_shifter #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .X      (X),
    .Y      (Y),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] x, input int n, input logic [1:0] o);
    case (o)
      2'b00:   return x << n;
      2'b01:   return x >> n;
      2'b10:   return 32'($signed(x) >>> n);
      default: return x;
    endcase
  endfunction

  function automatic int ref_lat(input int n, input logic [1:0] o);
    if (n == 0 || o == 2'b11) return 1;
`ifdef SERIAL_SHIFTER_FAST2_EN
    return (n + 1) / 2 + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and follow it to completion; noise toggles start and scrambles inputs while busy.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [1:0] o, input bit noise);
    int lat;
    int busy_lo;
    logic [31:0] exp_res;
    exp_res = ref_res(x, int'(y[4:0]), o);
    start = 1'b1; X = x; Y = y; op = o;
    lat = 0;
    busy_lo = 0;
    forever begin
      tick();
      lat++;
      if (done || lat >= 100) break;
      if (!busy) busy_lo++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      X = $urandom; Y = $urandom; op = 2'($urandom_range(0, 3));
    end
    chk($sformatf("%s_lat", tag), 32'(lat), 32'(ref_lat(int'(y[4:0]), o)));
    chk($sformatf("%s_res", tag), result, exp_res);
    chk($sformatf("%s_busy_run", tag), 32'(busy_lo), 32'd0);
    chk($sformatf("%s_busy_done", tag), {31'd0, busy}, 32'd1);
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    start = 1'b0;
    chk($sformatf("%s_pulse", tag), {31'd0, done}, 32'd0);
    chk($sformatf("%s_idle", tag), {31'd0, busy}, 32'd0);
    tick();
    chk($sformatf("%s_stay_idle", tag), {31'd0, busy}, 32'd0);
    chk($sformatf("%s_hold", tag), result, exp_res);
  endtask

  initial begin
    int ndone;
    int first_done;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; X = '0; Y = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle%0d_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("idle%0d_done", i), {31'd0, done}, 32'd0);
      chk($sformatf("idle%0d_res", i), result, 32'h0);
    end

    do_op("sll31", 32'h0000_0001, 32'h0000_001F, 2'b00, 1'b0);
    chk("sll31_val", result, 32'h8000_0000);
    do_op("sra4", 32'hF000_0000, 32'd4, 2'b10, 1'b0);
    chk("sra4_val", result, 32'hFF00_0000);
    do_op("srl4", 32'hF000_0000, 32'd4, 2'b01, 1'b0);
    chk("srl4_val", result, 32'h0F00_0000);
    do_op("zero", 32'h1234_5678, 32'hFFFF_FFE0, 2'b00, 1'b0);
    chk("zero_val", result, 32'h1234_5678);
    do_op("pass", 32'h1234_5678, 32'd7, 2'b11, 1'b0);
    chk("pass_val", result, 32'h1234_5678);
    do_op("sra31", 32'h8000_0000, 32'd31, 2'b10, 1'b0);
    chk("sra31_val", result, 32'hFFFF_FFFF);
    do_op("srl31", 32'h8000_0000, 32'd31, 2'b01, 1'b0);
    chk("srl31_val", result, 32'h0000_0001);
    do_op("srl1", 32'hFFFF_FFFF, 32'd1, 2'b01, 1'b0);
    do_op("sll2", 32'h0000_0003, 32'd2, 2'b00, 1'b0);

    // Start while busy: retries on the 2nd and 4th cycle must be dropped.
    start = 1'b1; X = 32'h0000_0080; Y = 32'd3; op = 2'b01;
    ndone = 0;
    first_done = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      start = (c == 1 || c == 3);
      X = 32'hFFFF_FFFF;
    end
    chk("busy_ndone", 32'(ndone), 32'd1);
    chk("busy_lat", 32'(first_done), 32'(ref_lat(3, 2'b01)));
    chk("busy_res", result, 32'h0000_0010);

    // Reset mid-operation.
    start = 1'b1; X = 32'hAAAA_AAAA; Y = 32'd20; op = 2'b00;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 6; c++) tick();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_res", result, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("mid_no_done", 32'(ndone), 32'd0);
    do_op("after_rst", 32'h0000_0003, 32'd1, 2'b00, 1'b0);
    chk("after_rst_val", result, 32'h0000_0006);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] rx, ry;
      logic [1:0]  ro;
      rx = $urandom;
      ry = $urandom;
      ro = 2'($urandom_range(0, 3));
      if (i % 8 == 0) ry[4:0] = 5'd0;
      do_op($sformatf("rnd%0d", i), rx, ry, ro, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_shifter.md
Name: serial_shifter

Overview:
- Multi-cycle shift unit in the EX stage. It consumes the ALU operand pair (X, Y) produced by the operand-select logic and executes SLL/SRL/SRA one bit position per clock.
- Y carries the shift amount in bits [4:0]; this is the zero-extended shamt path or B for variable shifts.
- Start/busy/done handshake toward the pipeline control, which stalls while busy.

Parameters:
- WIDTH, 32, data width of X, Y and result; the shift count uses Y[4:0] (log2 WIDTH bits).

Ports:
- clk  input  1  single clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through (no shift)
- X  input  WIDTH  value to shift
- Y  input  WIDTH  shift amount source; only Y[4:0] used, upper bits ignored
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  shifted value; holds last result until next completion

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, acc=0, count=0, result=0, busy=0, done=0. Reset mid-operation aborts immediately; no done pulse is produced for the aborted request.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at a rising edge, latch acc<=X, opr<=op, count<=Y[4:0].
  - If count==0 or op==11: go to DONE.
  - Otherwise: go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT: each edge updates acc by one bit and decrements count.
  - SLL: acc<={acc[WIDTH-2:0],0}.
  - SRL: acc<={0,acc[WIDTH-1:1]}.
  - SRA: acc<={acc[WIDTH-1],acc[WIDTH-1:1]}.
  - When count reaches 0 on this edge (count was 1), go to DONE and load result with the final shifted value.
- DONE: done=1 and busy=1 for exactly one cycle. Next edge returns to IDLE unconditionally.
- Entering DONE directly from IDLE (count 0 or op 11): result<=X.
- Latency: done is visible N+1 rising edges after the edge that samples start, where N=Y[4:0]. op 11 always has latency 1.
- start while busy (SHIFT or DONE) is ignored, not queued. X, Y and op may change freely after the capture edge.
- Back-to-back: start may be asserted in the cycle done is high; it is sampled on the following edge only if IDLE has been reached, so the minimum issue interval is N+2 cycles.
- result changes only on entry to DONE or on reset.
- Shift amount of 31 on SRA of a negative value yields all ones. SRL of the same value yields 1.

Optional Feature:
- Macro SERIAL_SHIFTER_FAST2_EN.
- Defined: in SHIFT, when count>=2 the shift is two bit positions per edge and count decrements by 2; when count==1, a single-bit step is taken.
  - Latency becomes ceil(N/2)+1 edges.
  - All other rules are unchanged: done pulse width, ignore-while-busy, N=0 and op 11 latency 1.
- Undefined: strictly one bit per edge as above.

Test Plan:
- Reset then idle: rst_n low, then high with start=0 for 10 cycles -> busy=0, done=0, result=0x00000000 throughout.
- SLL: X=0x00000001, Y=0x0000001F, op=00, start pulse -> done after 32 edges, result=0x80000000, busy high for 32 cycles. With FAST2_EN: done after 17 edges.
- SRA/SRL sign handling: X=0xF0000000, Y=4.
  - op=10 -> result=0xFF000000 after 5 edges.
  - op=01 -> result=0x0F000000.
- Zero shift and pass-through: X=0x12345678, Y=0xFFFFFFE0 (Y[4:0]=0), op=00 -> done after 1 edge, result=0x12345678. Same X with op=11, Y=7 -> result=0x12345678 after 1 edge.
- Start while busy: start X=0x00000080, Y=3, op=01, then reassert start with X=0xFFFFFFFF on the 2nd and 4th cycle -> a single done pulse, result=0x00000010, second request dropped.
- Reset mid-operation: start X=0xAAAAAAAA, Y=20, op=00; pull rst_n low at cycle 6 -> busy, done and result go to 0 immediately. No done pulse after release; a new request X=3, Y=1, op=00 completes normally with result=0x00000006.
